layer_ser: RTL and testbench

LAYER_SER -- requirements
Module: layer_ser

---
 rtl/layer_ser.sv | 128 ++++++++++++
 tb/tb_layer_ser.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/layer_ser.sv
// layer_ser: snapshots one layer's neuron results and streams them out as beats.
// Optional ReLU clamp at capture when LAYER_SER_RELU_EN is defined.
module layer_ser #(
  parameter int N_NEURONS = 3,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          nin_done,
  input  logic [N_NEURONS*DATA_W-1:0]   nin_data,
  output logic [DATA_W-1:0]             out_data,
  output logic [IDX_W-1:0]              out_idx,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic                          missed
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURONS - 1);

  state_t                      st_q, st_d;
  logic [IDX_W-1:0]            idx_q, idx_d, nxt;
  logic [N_NEURONS*DATA_W-1:0] buf_q, buf_d, cap;
  logic [DATA_W-1:0]           data_d;
  logic [IDX_W-1:0]            oidx_d;
  logic                        valid_d, last_d, busy_d;
  logic                        done_d, missed_d;

  // Elements as they will be stored in the buffer
  always_comb begin
    cap = nin_data;
`ifdef LAYER_SER_RELU_EN
    for (int k = 0; k < N_NEURONS; k++) begin
      if (nin_data[k*DATA_W + DATA_W - 1])
        cap[k*DATA_W +: DATA_W] = '0;
    end
`endif
  end

  // Next state, next index and next registered outputs
  always_comb begin
    st_d     = st_q;
    idx_d    = idx_q;
    buf_d    = buf_q;
    data_d   = out_data;
    oidx_d   = out_idx;
    valid_d  = out_valid;
    last_d   = out_last;
    busy_d   = busy;
    done_d   = 1'b0;
    missed_d = missed;
    nxt      = idx_q + 1'b1;
    unique case (st_q)
      IDLE: begin
        if (nin_done) begin
          st_d    = SEND;
          buf_d   = cap;
          idx_d   = '0;
          data_d  = cap[DATA_W-1:0];
          oidx_d  = '0;
          valid_d = 1'b1;
          last_d  = (LAST == '0);
          busy_d  = 1'b1;
        end
      end
      SEND: begin
        if (nin_done)
          missed_d = 1'b1;
        if (out_ready) begin
          if (idx_q == LAST) begin
            st_d    = DONE;
            idx_d   = '0;
            data_d  = '0;
            oidx_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = nxt;
            data_d = buf_q[int'(nxt)*DATA_W +: DATA_W];
            oidx_d = nxt;
            last_d = (nxt == LAST);
          end
        end
      end
      DONE: begin
        if (nin_done)
          missed_d = 1'b1;
        st_d   = IDLE;
        busy_d = 1'b0;
      end
      default: st_d = IDLE;
    endcase
  end

  // State, buffer and output registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= IDLE;
      idx_q     <= '0;
      buf_q     <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      missed    <= 1'b0;
    end else begin
      st_q      <= st_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      out_data  <= data_d;
      out_idx   <= oidx_d;
      out_valid <= valid_d;
      out_last  <= last_d;
      busy      <= busy_d;
      done      <= done_d;
      missed    <= missed_d;
    end
  end

endmodule

// File: tb/tb_layer_ser.sv
// tb_layer_ser: vector table of layer passes plus reset corner sequences.
// Expected beats go through a scoreboard queue.
module tb_layer_ser;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           nin_done;
  logic [N*W-1:0] nin_data;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_idx;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic           busy;
  logic           done;
  logic           missed;

  layer_ser #(.N_NEURONS(N), .DATA_W(W), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .nin_done(nin_done), .nin_data(nin_data),
    .out_data(out_data), .out_idx(out_idx),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy),
    .done(done), .missed(missed)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;
  bit missed_exp = 1'b0;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  typedef struct {
    logic [N*W-1:0] e;
    logic [31:0]    mask;
    int             inj;
  } vec_t;

  beat_t sb[$];
  vec_t  vt[6];

  task automatic chk(input string nm, input int id,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s vec%0d: got %0h want %0h", nm, id, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] relu(input logic [W-1:0] v);
`ifdef LAYER_SER_RELU_EN
    return v[W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic run_pass(input vec_t v, input int id);
    beat_t b, prev, exp;
    bit    held, fin;
    int    cyc, want, cnt;
    want = 0;
    cnt  = 0;
    for (int i = 0; i < 32; i++) begin
      if (v.mask[i] && cnt < N) begin
        cnt++;
        if (cnt == N) want = i + 1;
      end
    end
    for (int k = 0; k < N; k++)
      sb.push_back({relu(v.e[k*W +: W]), IW'(k), k == N - 1});
    nin_data  = v.e;
    nin_done  = 1'b1;
    out_ready = 1'b0;
    tick;
    held = 1'b0;
    fin  = 1'b0;
    cyc  = 0;
    prev = '0;
    while (!fin && cyc < 64) begin
      nin_done  = (cyc == v.inj);
      nin_data  = (cyc == v.inj) ? {N{32'hAAAAAAAA}} : {N{32'h55555555}};
      out_ready = (cyc < 32) ? v.mask[cyc] : 1'b1;
      b = {out_data, out_idx, out_last};
      chk("valid", id, out_valid, 1);
      chk("busy", id, busy, 1);
      chk("missed", id, missed, missed_exp);
      if (held) chk("hold", id, b, prev);
      if (out_valid && out_ready) begin
        if (sb.size() != 0) exp = sb.pop_front();
        else exp = beat_t'('1);
        chk("beat", id, b, exp);
        held = 1'b0;
        if (exp.last) fin = 1'b1;
      end else begin
        held = out_valid;
        prev = b;
      end
      tick;
      if (cyc == v.inj) missed_exp = 1'b1;
      cyc++;
    end
    chk("beat_cycles", id, cyc, want);
    nin_done  = 1'b0;
    out_ready = 1'b0;
    chk("done_pulse", id, done, 1);
    chk("done_beat", id, {out_valid, out_last, out_idx, out_data}, 0);
    chk("done_busy", id, busy, 1);
    chk("done_missed", id, missed, missed_exp);
    tick;
    chk("idle_done", id, done, 0);
    chk("idle_busy", id, busy, 0);
    chk("idle_valid", id, out_valid, 0);
    sb.delete();
  endtask

  initial begin
    vt[0] = '{e: {32'h33, 32'h22, 32'h11}, mask: 32'hFFFFFFFF, inj: -1};
    vt[1] = '{e: {32'h33, 32'h22, 32'h11}, mask: 32'hFFFFFFF9, inj: -1};
    vt[2] = '{e: {32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFF0},
              mask: 32'hFFFFFFFF, inj: -1};
    vt[3] = '{e: {$urandom, $urandom, $urandom},
              mask: $urandom | 32'hFFFF0000, inj: -1};
    vt[4] = '{e: {32'h33, 32'h22, 32'h11}, mask: 32'hFFFFFFFF, inj: 1};
    vt[5] = '{e: {32'h66, 32'h55, 32'h44}, mask: 32'hFFFFFFFF, inj: -1};

    rst       = 1'b1;
    nin_done  = 1'b0;
    nin_data  = '0;
    out_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_data", 0, out_data, 0);
    chk("rst_idx", 0, out_idx, 0);
    chk("rst_flags", 0, {out_valid, out_last, busy, done, missed}, 0);

    for (int i = 0; i < 6; i++)
      run_pass(vt[i], i);

    nin_data  = {32'h33, 32'h22, 32'h11};
    nin_done  = 1'b1;
    out_ready = 1'b1;
    tick;
    nin_done = 1'b0;
    chk("mid_beat0", 10, {out_valid, out_data}, {1'b1, 32'h11});
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    missed_exp = 1'b0;
    chk("mid_rst_valid", 10, out_valid, 0);
    chk("mid_rst_busy", 10, busy, 0);
    chk("mid_rst_missed", 10, missed, 0);
    chk("mid_rst_data", 10, out_data, 0);
    for (int i = 0; i < 4; i++) begin
      chk("mid_no_done", 10, {done, out_valid}, 0);
      tick;
    end

    rst      = 1'b1;
    nin_done = 1'b1;
    tick;
    rst      = 1'b0;
    nin_done = 1'b0;
    chk("prio_busy", 11, busy, 0);
    chk("prio_valid", 11, out_valid, 0);
    tick;
    chk("prio_idle", 11, {busy, out_valid}, 0);

    run_pass(vt[0], 12);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
